muldiv_unit: RTL and testbench

//  Iterative RV32M/RV64M multiply/divide unit with a valid/ready handshake on both sides.

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_step.sv | 51 +++++
 rtl/muldiv_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : muldiv_pkg                                             |
// | Description : Shared definitions for the iterative mul/div unit:     |
// |               ALU operation codes, FSM state encoding and the        |
// |               most-negative-value helper.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package muldiv_pkg;

    // M-extension operation codes on the alucode bus
    localparam logic [5:0] ALU_MUL    = 6'h10;
    localparam logic [5:0] ALU_MULH   = 6'h11;
    localparam logic [5:0] ALU_MULHSU = 6'h12;
    localparam logic [5:0] ALU_MULHU  = 6'h13;
    localparam logic [5:0] ALU_DIV    = 6'h14;
    localparam logic [5:0] ALU_DIVU   = 6'h15;
    localparam logic [5:0] ALU_REM    = 6'h16;
    localparam logic [5:0] ALU_REMU   = 6'h17;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Most negative two's-complement value for a given width (1 << (xlen-1))
    function automatic logic [63:0] xlen_min(input int xlen);
        return 64'd1 << (xlen - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : muldiv_step                                            |
// | Description : One radix-2 iteration. Multiply: add shifted           |
// |               multiplicand when the current multiplier LSB is set.   |
// |               Divide: restoring trial subtract, one quotient bit.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              i_is_div,
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [2*XLEN-1:0] i_mcand,
    input  logic [XLEN-1:0]   i_b,
    input  logic [XLEN-1:0]   i_rem,
    input  logic [XLEN-1:0]   i_dvsr,
    output logic [2*XLEN-1:0] o_acc,
    output logic [2*XLEN-1:0] o_mcand,
    output logic [XLEN-1:0]   o_b,
    output logic [XLEN-1:0]   o_rem
);

    logic [XLEN:0]   w_rem_sh;
    logic [XLEN-1:0] w_sub;
    logic            w_ge;

    // Single iteration; i_b is the multiplier (mul) or dividend/quotient (div)
    always_comb begin
        w_rem_sh = {i_rem, i_b[XLEN-1]};
        w_ge     = (w_rem_sh >= {1'b0, i_dvsr});
        // Only used when w_ge, where the true difference fits in XLEN bits
        w_sub    = w_rem_sh[XLEN-1:0] - i_dvsr;
        o_acc    = i_acc;
        o_mcand  = i_mcand;
        o_b      = i_b;
        o_rem    = i_rem;
        if (i_is_div) begin
            o_rem = w_ge ? w_sub : w_rem_sh[XLEN-1:0];
            o_b   = {i_b[XLEN-2:0], w_ge};
        end else begin
            if (i_b[0]) begin
                o_acc = i_acc + i_mcand;
            end
            o_mcand = {i_mcand[2*XLEN-2:0], 1'b0};
            o_b     = {1'b0, i_b[XLEN-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : muldiv_unit                                            |
// | Description : Iterative RV32M/RV64M multiply/divide unit with        |
// |               valid/ready handshakes, kill, back-pressure and        |
// |               single-cycle special cases.                            |
// |               Optional macro MULDIV_EARLY_OUT_EN: CALC terminates    |
// |               early (mul: multiplier exhausted; div: leading zeros   |
// |               of |op1| skipped up front).                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ALUCODE_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 kill,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ALUCODE_W-1:0] alucode,
    input  logic [XLEN-1:0]      op1,
    input  logic [XLEN-1:0]      op2,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [XLEN-1:0]      result,
    output logic                 busy
);

    localparam int                   CW         = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]        c_last     = CW'(XLEN - 1);
    localparam logic [XLEN-1:0]      c_min      = XLEN'(xlen_min(XLEN));
    localparam logic [XLEN-1:0]      c_ones     = '1;
    localparam logic [ALUCODE_W-1:0] c_mul      = ALUCODE_W'(ALU_MUL);
    localparam logic [ALUCODE_W-1:0] c_mulh     = ALUCODE_W'(ALU_MULH);
    localparam logic [ALUCODE_W-1:0] c_mulhsu   = ALUCODE_W'(ALU_MULHSU);
    localparam logic [ALUCODE_W-1:0] c_mulhu    = ALUCODE_W'(ALU_MULHU);
    localparam logic [ALUCODE_W-1:0] c_div      = ALUCODE_W'(ALU_DIV);
    localparam logic [ALUCODE_W-1:0] c_divu     = ALUCODE_W'(ALU_DIVU);
    localparam logic [ALUCODE_W-1:0] c_rem      = ALUCODE_W'(ALU_REM);
    localparam logic [ALUCODE_W-1:0] c_remu     = ALUCODE_W'(ALU_REMU);

    state_e                r_state, w_state_nxt;
    logic [ALUCODE_W-1:0]  r_code;
    logic [XLEN-1:0]       r_op1, r_op2, r_b, r_rem, r_dvsr, r_result;
    logic [2*XLEN-1:0]     r_acc, r_mcand;
    logic [CW-1:0]         r_cnt;
    logic                  r_neg, r_neg_rem;

    logic                  w_is_div, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
    logic [XLEN-1:0]       w_abs_a, w_abs_b, w_quo, w_remv, w_fix;
    logic [2*XLEN-1:0]     w_prod, w_acc_nxt, w_mcand_nxt;
    logic [XLEN-1:0]       w_b_nxt, w_rem_nxt;
    logic [CW-1:0]         w_skip;
    logic                  w_calc_last, w_special;
    logic [XLEN-1:0]       w_spec_res;

    assign req_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign resp_valid = (r_state == DONE);
    assign result     = r_result;

`ifdef MULDIV_EARLY_OUT_EN
    // Leading-zero count capped at XLEN-1 so CALC always runs at least one step
    function automatic logic [CW-1:0] f_lzc(input logic [XLEN-1:0] v);
        logic [CW-1:0] n;
        n = CW'(XLEN - 1);
        for (int i = 0; i < XLEN; i++) begin
            if (v[i]) n = CW'(XLEN - 1 - i);
        end
        return n;
    endfunction
`endif

    // Operand signedness of the latched operation
    always_comb begin
        w_is_div = 1'b0;
        w_sgn_a  = 1'b0;
        w_sgn_b  = 1'b0;
        case (r_code)
            c_mulh:         begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            c_mulhsu:       w_sgn_a = 1'b1;
            c_div, c_rem:   begin w_is_div = 1'b1; w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            c_divu, c_remu: w_is_div = 1'b1;
            default:        ;
        endcase
    end

    assign w_neg_a = w_sgn_a & r_op1[XLEN-1];
    assign w_neg_b = w_sgn_b & r_op2[XLEN-1];
    assign w_abs_a = w_neg_a ? -r_op1 : r_op1;
    assign w_abs_b = w_neg_b ? -r_op2 : r_op2;

`ifdef MULDIV_EARLY_OUT_EN
    assign w_skip = w_is_div ? f_lzc(w_abs_a) : '0;
`else
    assign w_skip = '0;
`endif

    muldiv_step #(.XLEN(XLEN)) u_step (
        .i_is_div (w_is_div),
        .i_acc    (r_acc),
        .i_mcand  (r_mcand),
        .i_b      (r_b),
        .i_rem    (r_rem),
        .i_dvsr   (r_dvsr),
        .o_acc    (w_acc_nxt),
        .o_mcand  (w_mcand_nxt),
        .o_b      (w_b_nxt),
        .o_rem    (w_rem_nxt)
    );

`ifdef MULDIV_EARLY_OUT_EN
    assign w_calc_last = (r_cnt == c_last) || (!w_is_div && (w_b_nxt == '0));
`else
    assign w_calc_last = (r_cnt == c_last);
`endif

    // Requests resolvable without iterating: divide by zero, signed overflow, unknown code
    always_comb begin
        w_special  = 1'b0;
        w_spec_res = '0;
        case (alucode)
            c_mul, c_mulh, c_mulhsu, c_mulhu: ;
            c_div: begin
                if (op2 == '0) begin
                    w_special = 1'b1; w_spec_res = c_ones;
                end else if (op1 == c_min && op2 == c_ones) begin
                    w_special = 1'b1; w_spec_res = c_min;
                end
            end
            c_divu: if (op2 == '0) begin w_special = 1'b1; w_spec_res = c_ones; end
            c_rem: begin
                if (op2 == '0) begin
                    w_special = 1'b1; w_spec_res = op1;
                end else if (op1 == c_min && op2 == c_ones) begin
                    w_special = 1'b1;
                end
            end
            c_remu: if (op2 == '0) begin w_special = 1'b1; w_spec_res = op1; end
            default: w_special = 1'b1;
        endcase
    end

    // Sign correction and result selection applied in FIX
    always_comb begin
        w_prod = r_neg ? -r_acc : r_acc;
        w_quo  = r_neg ? -r_b : r_b;
        w_remv = r_neg_rem ? -r_rem : r_rem;
        case (r_code)
            c_mul:                     w_fix = w_prod[XLEN-1:0];
            c_mulh, c_mulhsu, c_mulhu: w_fix = w_prod[2*XLEN-1:XLEN];
            c_div, c_divu:             w_fix = w_quo;
            c_rem, c_remu:             w_fix = w_remv;
            default:                   w_fix = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; kill forces IDLE from any state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_state_nxt = w_special ? DONE : PREP;
            PREP:    w_state_nxt = CALC;
            CALC:    if (w_calc_last) w_state_nxt = FIX;
            FIX:     w_state_nxt = DONE;
            DONE:    if (resp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (kill) w_state_nxt = IDLE;
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code    <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_b       <= '0;
            r_rem     <= '0;
            r_dvsr    <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= '0;
        end else if (!kill) begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_code <= alucode;
                        r_op1  <= op1;
                        r_op2  <= op2;
                        if (w_special) r_result <= w_spec_res;
                    end
                end
                PREP: begin
                    r_acc     <= '0;
                    r_mcand   <= {{XLEN{1'b0}}, w_abs_a};
                    r_b       <= w_is_div ? (w_abs_a << w_skip) : w_abs_b;
                    r_rem     <= '0;
                    r_dvsr    <= w_abs_b;
                    r_cnt     <= w_skip;
                    r_neg     <= w_neg_a ^ w_neg_b;
                    r_neg_rem <= w_neg_a;
                end
                CALC: begin
                    r_acc   <= w_acc_nxt;
                    r_mcand <= w_mcand_nxt;
                    r_b     <= w_b_nxt;
                    r_rem   <= w_rem_nxt;
                    r_cnt   <= r_cnt + CW'(1);
                end
                FIX:     r_result <= w_fix;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_muldiv_unit                                         |
// | Description : Self-checking bench for muldiv_unit (XLEN=32): vector  |
// |               table with hand-computed results and latencies,        |
// |               random ops against an arithmetic model, and directed   |
// |               back-pressure / kill / reset sequences.                |
// |               Latency expectations relax under MULDIV_EARLY_OUT_EN.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kill = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  alucode = '0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    muldiv_unit #(.XLEN(32), .ALUCODE_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .kill       (kill),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .alucode    (alucode),
        .op1        (op1),
        .op2        (op2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request, wait (bounded) for the response, then drain it
    task automatic run_op(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        alucode = code; op1 = a; op2 = b; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res = result;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    // Count cycles in which resp_valid is seen over a window
    task automatic watch_no_resp(input int cycles, output int seen);
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [5:0] code, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic        [63:0] ua, ub, p;
        logic signed [31:0] sa32, sb32, q;
        sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
        ua = {32'd0, a};       ub = {32'd0, b};
        sa32 = a;              sb32 = b;
        case (code)
            ALU_MUL:    begin p = ua * ub;          return p[31:0];  end
            ALU_MULH:   begin p = sa * sb;          return p[63:32]; end
            ALU_MULHSU: begin p = sa * $signed(ub); return p[63:32]; end
            ALU_MULHU:  begin p = ua * ub;          return p[63:32]; end
            ALU_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = sa32 / sb32; return q;
            end
            ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                q = sa32 % sb32; return q;
            end
            ALU_REMU:   return (b == 0) ? a : a % b;
            default:    return 32'd0;
        endcase
    endfunction

    logic [31:0] res;
    int          lat, seen;
    logic [5:0]  codes[8];
    logic [5:0]  rc;
    logic [31:0] ra, rb;

    initial begin
        vecs[0]  = '{ALU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 35};
        vecs[1]  = '{ALU_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 35};
        vecs[2]  = '{ALU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 35};
        vecs[3]  = '{ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 35};
        vecs[4]  = '{ALU_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 35};
        vecs[5]  = '{ALU_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 35};
        vecs[6]  = '{ALU_DIVU,   32'd100,        32'd7,         32'd14,        35};
        vecs[7]  = '{ALU_REMU,   32'd100,        32'd7,         32'd2,         35};
        vecs[8]  = '{ALU_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{ALU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        vecs[10] = '{ALU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{ALU_REMU,   32'h0000_1234,  32'd0,         32'h0000_1234, 1};
        vecs[12] = '{ALU_DIVU,   32'h0000_1234,  32'd0,         32'hFFFF_FFFF, 1};
        vecs[13] = '{6'h3F,      32'd5,          32'd5,         32'd0,         1};
        vecs[14] = '{ALU_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         35};
        vecs[15] = '{ALU_MULH,   32'hFFFF_FFFF,  32'd5,         32'hFFFF_FFFF, 35};
        vecs[16] = '{ALU_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         35};
        vecs[17] = '{ALU_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 35};
        vecs[18] = '{ALU_DIV,    32'h8000_0000,  32'd1,         32'h8000_0000, 35};
        vecs[19] = '{ALU_MULHU,  32'd0,          32'h1234_5678, 32'd0,         35};
        codes = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

        // Reset values while rst is held
        @(negedge clk); @(negedge clk);
        chk("rst resp_valid", resp_valid, 0);
        chk("rst result",     result,     0);
        chk("rst busy",       busy,       0);
        chk("rst req_ready",  req_ready,  1);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 20; i++) begin
            run_op(vecs[i].code, vecs[i].a, vecs[i].b, res, lat);
            chk($sformatf("v%0d result", i), res, vecs[i].exp);
`ifdef MULDIV_EARLY_OUT_EN
            chk($sformatf("v%0d latency", i),
                (vecs[i].lat == 1) ? lat : ((lat >= 4 && lat <= 35) ? 35 : lat), vecs[i].lat);
`else
            chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
`endif
        end

        // Random operations against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            rc = codes[$urandom_range(0, 7)];
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = $urandom_range(0, 3);
                3: ra = $urandom_range(0, 255);
                default: ;
            endcase
            run_op(rc, ra, rb, res, lat);
            chk($sformatf("rnd%0d code %0h a %0h b %0h", i, rc, ra, rb), res, ref_model(rc, ra, rb));
        end

        // Back-pressure: result held, no accept while undrained
        @(negedge clk);
        alucode = ALU_MUL; op1 = 32'd7; op2 = 32'hFFFF_FFFD; req_valid = 1'b1;
        @(negedge clk);
        lat = 1;
        alucode = ALU_DIV; op1 = 32'd1; op2 = 32'd0;
        while (!resp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("bp resp_valid", resp_valid, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("bp result c%0d", k), result, 32'hFFFF_FFEB);
            chk($sformatf("bp req_ready c%0d", k), req_ready, 0);
            chk($sformatf("bp resp_valid c%0d", k), resp_valid, 1);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp drained resp_valid", resp_valid, 0);
        chk("bp drained req_ready",  req_ready,  1);

        // Response taken in the same cycle it appears
        alucode = ALU_DIV; op1 = 32'd9; op2 = 32'd0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("same-cycle resp_valid", resp_valid, 1);
        chk("same-cycle result",     result,     32'hFFFF_FFFF);
        @(negedge clk);
        chk("same-cycle resp_valid next", resp_valid, 0);
        chk("same-cycle req_ready next",  req_ready,  1);
        resp_ready = 1'b0;

        // Kill in CALC cycle 5
        alucode = ALU_DIVU; op1 = 32'd100; op2 = 32'd7; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 5; k++) @(negedge clk);
        chk("kill busy before", busy, 1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill req_ready",  req_ready,  1);
        chk("kill busy",       busy,       0);
        chk("kill resp_valid", resp_valid, 0);
        chk("kill result",     result,     32'hFFFF_FFFF);
        watch_no_resp(40, seen);
        chk("kill no response", seen, 0);

        // Kill alongside a request in IDLE drops the request
        alucode = ALU_MUL; op1 = 32'd3; op2 = 32'd3; req_valid = 1'b1; kill = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; kill = 1'b0;
        chk("kill idle busy",      busy,      0);
        chk("kill idle req_ready", req_ready, 1);
        watch_no_resp(40, seen);
        chk("kill idle no response", seen, 0);

        // Asynchronous reset mid-CALC
        alucode = ALU_MULHU; op1 = 32'hFFFF_FFFF; op2 = 32'hFFFF_FFFF; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 10; k++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid rst result",     result,     0);
        chk("mid rst resp_valid", resp_valid, 0);
        chk("mid rst busy",       busy,       0);
        chk("mid rst req_ready",  req_ready,  1);
        @(negedge clk);
        rst = 1'b0;
        watch_no_resp(40, seen);
        chk("mid rst no response", seen, 0);
        run_op(ALU_DIVU, 32'd100, 32'd7, res, lat);
        chk("post rst result", res, 32'd14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
